// File: rtl/lcd_pkg.sv
// Shared colour constants, pattern-mode encodings and the 8-entry bar palette
// for the LCD test-pattern generator.
package lcd_pkg;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  typedef enum logic [2:0] {
    MODE_BARS   = 3'd0,
    MODE_CHECK  = 3'd1,
    MODE_RAMP   = 3'd2,
    MODE_BORDER = 3'd3,
    MODE_BOX    = 3'd4
  } mode_e;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = BLACK;
      3'd2:    c = RED;
      3'd3:    c = GREEN;
      3'd4:    c = BLUE;
      3'd5:    c = YELLOW;
      3'd6:    c = CYAN;
      default: c = MAGENTA;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel stream between the LCD timing driver and the pattern generator:
// coordinates/strobe in, RGB and aligned strobe out.
interface lcd_pattern_gen_if #(
  parameter int COLOR_W = 8,
  parameter int XY_W    = 11
);
  logic                   de;
  logic [XY_W-1:0]        pixel_xpos;
  logic [XY_W-1:0]        pixel_ypos;
  logic [3*COLOR_W-1:0]   pixel_data;
  logic                   pixel_de;

  modport master (output de, pixel_xpos, pixel_ypos, input pixel_data, pixel_de);
  modport slave  (input de, pixel_xpos, pixel_ypos, output pixel_data, pixel_de);
endinterface

// File: rtl/lcd_bar_index.sv
// Divider-free colour-bar index: bar_idx = floor(x*NUM_BARS/h_disp) for the
// current de pixel, tracked with a running remainder that restarts at x==0.
module lcd_bar_index #(
  parameter int NUM_BARS = 5,
  parameter int XY_W     = 11,
  parameter int IDX_W    = 7
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic              de,
  input  logic [XY_W-1:0]   pixel_xpos,
  input  logic [XY_W-1:0]   h_disp,
  output logic [IDX_W-1:0]  bar_idx
);

  localparam int ACC_W = XY_W + 1;
  localparam logic [ACC_W-1:0] STEP    = ACC_W'(NUM_BARS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] h_ext;
  logic [IDX_W-1:0] idx_r;

  // Registered acc/idx already describe the next pixel; x==0 forces a fresh line.
  always_comb begin
    h_ext   = {1'b0, h_disp};
    acc_cur = (pixel_xpos == '0) ? '0 : acc_r;
    bar_idx = (pixel_xpos == '0) ? '0 : idx_r;
    acc_sum = acc_cur + STEP;
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (de) begin
      if (acc_sum >= h_ext) begin
        acc_r <= acc_sum - h_ext;
        idx_r <= bar_idx + IDX_ONE;
      end else begin
        acc_r <= acc_sum;
        idx_r <= bar_idx;
      end
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Parametrised LCD test-pattern source: bars, checkerboard, ramp, border and a
// bouncing box, with mode changes and box motion taken only at frame start.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int COLOR_W   = 8,
  parameter int NUM_BARS  = 5,
  parameter int CELL_LOG2 = 5,
  parameter int BOX_SIZE  = 64,
  parameter int XY_W      = 11
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  lcd_pattern_gen_if.slave  vid,
  input  logic [XY_W-1:0]   h_disp,
  input  logic [XY_W-1:0]   v_disp,
  input  logic [2:0]        mode_sel,
  output logic [2:0]        cur_mode
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int IDX_W = 7;
  localparam int EXT_W = XY_W + 1;
  localparam logic [EXT_W-1:0] BOX_EXT = EXT_W'(BOX_SIZE);
  localparam logic [XY_W-1:0]  ONE_XY  = XY_W'(1);

  logic              frame_start_p0;
  logic [2:0]        mode_p0;
  logic [IDX_W-1:0]  bar_idx_p0;
  logic [XY_W-1:0]   box_x, box_y, box_x_nxt, box_y_nxt, box_x_p0, box_y_p0;
  logic              dir_x, dir_y, dir_x_nxt, dir_y_nxt;
  logic              in_box_p0;
  logic [EXT_W-1:0]  x_ext, y_ext;
  logic [23:0]       rgb_p0;
  logic [PIX_W-1:0]  pix_data_p1;
  logic              vld_p1;
  logic [2:0]        cur_mode_r;

  // One box axis step; returns {forward, position}. Edge hits reverse in place.
  function automatic logic [XY_W:0] axis_step(input logic [XY_W-1:0] pos,
                                               input logic            fwd,
                                               input logic [XY_W-1:0] disp);
    logic [XY_W:0] r;
    if (fwd) begin
      if (({1'b0, pos} + BOX_EXT) == {1'b0, disp}) r = {1'b0, pos - ONE_XY};
      else                                          r = {1'b1, pos + ONE_XY};
    end else begin
      if (pos == '0) r = {1'b1, pos + ONE_XY};
      else           r = {1'b0, pos - ONE_XY};
    end
    return r;
  endfunction

  function automatic logic [PIX_W-1:0] trunc_rgb(input logic [23:0] c);
    return {c[23 -: COLOR_W], c[15 -: COLOR_W], c[7 -: COLOR_W]};
  endfunction

  lcd_bar_index #(
    .NUM_BARS (NUM_BARS),
    .XY_W     (XY_W),
    .IDX_W    (IDX_W)
  ) u_bar_index (
    .lcd_pclk   (lcd_pclk),
    .rst        (rst),
    .de         (vid.de),
    .pixel_xpos (vid.pixel_xpos),
    .h_disp     (h_disp),
    .bar_idx    (bar_idx_p0)
  );

  // Stage p0: frame-start bypass so the new mode and box position hit pixel (0,0).
  always_comb begin
    frame_start_p0 = vid.de && (vid.pixel_xpos == '0) && (vid.pixel_ypos == '0);
    {dir_x_nxt, box_x_nxt} = axis_step(box_x, dir_x, h_disp);
    {dir_y_nxt, box_y_nxt} = axis_step(box_y, dir_y, v_disp);
    mode_p0  = frame_start_p0 ? mode_sel  : cur_mode_r;
    box_x_p0 = frame_start_p0 ? box_x_nxt : box_x;
    box_y_p0 = frame_start_p0 ? box_y_nxt : box_y;
    x_ext = {1'b0, vid.pixel_xpos};
    y_ext = {1'b0, vid.pixel_ypos};
    in_box_p0 = (x_ext >= {1'b0, box_x_p0}) && (x_ext < ({1'b0, box_x_p0} + BOX_EXT)) &&
                (y_ext >= {1'b0, box_y_p0}) && (y_ext < ({1'b0, box_y_p0} + BOX_EXT));
    rgb_p0 = BLACK;
    case (mode_p0)
      MODE_BARS:   rgb_p0 = palette(3'(bar_idx_p0));
      MODE_CHECK:  rgb_p0 = (vid.pixel_xpos[CELL_LOG2] ^ vid.pixel_ypos[CELL_LOG2]) ? BLACK : WHITE;
      MODE_RAMP:   rgb_p0 = {3{vid.pixel_xpos[9:2]}};
      MODE_BORDER: rgb_p0 = ((vid.pixel_xpos == '0) || (vid.pixel_ypos == '0) ||
                             (vid.pixel_xpos == h_disp - ONE_XY) ||
                             (vid.pixel_ypos == v_disp - ONE_XY)) ? WHITE : BLACK;
      MODE_BOX:    rgb_p0 = in_box_p0 ? RED : BLUE;
      default:     rgb_p0 = BLACK;
    endcase
  end

  // Stage p1: registered pixel output and per-frame state.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      pix_data_p1 <= '0;
      vld_p1      <= 1'b0;
      cur_mode_r  <= MODE_BARS;
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
    end else begin
      vld_p1      <= vid.de;
      pix_data_p1 <= vid.de ? trunc_rgb(rgb_p0) : '0;
      if (frame_start_p0) begin
        cur_mode_r <= mode_sel;
        box_x      <= box_x_nxt;
        box_y      <= box_y_nxt;
        dir_x      <= dir_x_nxt;
        dir_y      <= dir_y_nxt;
      end
    end
  end

  assign vid.pixel_data = pix_data_p1;
  assign vid.pixel_de   = vld_p1;
  assign cur_mode       = cur_mode_r;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: three instances (5 bars/8-bit, 7 bars/8-bit,
// 8 bars/5-bit) driven from one pixel stream.
module tb_lcd_pattern_gen;

  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic        de;
  logic [10:0] x, y, h_disp, v_disp;
  logic [2:0]  mode_sel;
  logic [2:0]  cur_mode_a, cur_mode_b, cur_mode_c;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_a;
  int          idx7, ebx, eby;

  logic [23:0] pal [8] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00,
                           24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_pattern_gen_if #(.COLOR_W(8), .XY_W(11)) vid_a ();
  lcd_pattern_gen_if #(.COLOR_W(8), .XY_W(11)) vid_b ();
  lcd_pattern_gen_if #(.COLOR_W(5), .XY_W(11)) vid_c ();

  assign vid_a.de = de;  assign vid_a.pixel_xpos = x;  assign vid_a.pixel_ypos = y;
  assign vid_b.de = de;  assign vid_b.pixel_xpos = x;  assign vid_b.pixel_ypos = y;
  assign vid_c.de = de;  assign vid_c.pixel_xpos = x;  assign vid_c.pixel_ypos = y;

  lcd_pattern_gen #(.COLOR_W(8), .NUM_BARS(5), .CELL_LOG2(5), .BOX_SIZE(64), .XY_W(11)) dut_a (
    .lcd_pclk(lcd_pclk), .rst(rst), .vid(vid_a), .h_disp(h_disp), .v_disp(v_disp),
    .mode_sel(mode_sel), .cur_mode(cur_mode_a));
  lcd_pattern_gen #(.COLOR_W(8), .NUM_BARS(7), .CELL_LOG2(5), .BOX_SIZE(64), .XY_W(11)) dut_b (
    .lcd_pclk(lcd_pclk), .rst(rst), .vid(vid_b), .h_disp(h_disp), .v_disp(v_disp),
    .mode_sel(mode_sel), .cur_mode(cur_mode_b));
  lcd_pattern_gen #(.COLOR_W(5), .NUM_BARS(8), .CELL_LOG2(5), .BOX_SIZE(64), .XY_W(11)) dut_c (
    .lcd_pclk(lcd_pclk), .rst(rst), .vid(vid_c), .h_disp(h_disp), .v_disp(v_disp),
    .mode_sel(mode_sel), .cur_mode(cur_mode_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel, then sample the registered result 1 ns after the edge.
  task automatic pix(input logic d, input int px, input int py);
    de = d;
    x  = 11'(px);
    y  = 11'(py);
    @(posedge lcd_pclk);
    #1;
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; x = '0; y = '0;
    h_disp = 11'd800; v_disp = 11'd600; mode_sel = 3'd0;
    repeat (2) @(posedge lcd_pclk);
    #1;
    chk("rst_data_a", 32'(vid_a.pixel_data), 32'h0);
    chk("rst_de_a",   32'(vid_a.pixel_de),   32'h0);
    chk("rst_mode_a", 32'(cur_mode_a),       32'h0);
    chk("rst_de_b",   32'(vid_b.pixel_de),   32'h0);
    chk("rst_mode_b", 32'(cur_mode_b),       32'h0);
    chk("rst_data_c", 32'(vid_c.pixel_data), 32'h0);
    chk("rst_mode_c", 32'(cur_mode_c),       32'h0);
    rst = 1'b0;

    // One full line of colour bars.
    for (int i = 0; i < 800; i++) begin
      pix(1'b1, i, 0);
      if      (i < 160) exp_a = 24'hFFFFFF;
      else if (i < 320) exp_a = 24'h000000;
      else if (i < 480) exp_a = 24'hFF0000;
      else if (i < 640) exp_a = 24'h00FF00;
      else              exp_a = 24'h0000FF;
      chk("bars5", 32'(vid_a.pixel_data), 32'(exp_a));
      idx7 = (i * 7) / 800;
      chk("bars7", 32'(vid_b.pixel_data), 32'(pal[3'(idx7 % 8)]));
      if (i == 0)   chk("mode0_a", 32'(cur_mode_a), 32'h0);
      if (i == 5)   chk("pix_de_a", 32'(vid_a.pixel_de), 32'h1);
      if (i == 250) chk("c5_red",    32'(vid_c.pixel_data), 32'h7C00);
      if (i == 550) chk("c5_yellow", 32'(vid_c.pixel_data), 32'h7FE0);
    end
    pix(1'b0, 800, 0);
    chk("blank_data_a", 32'(vid_a.pixel_data), 32'h0);
    chk("blank_de_a",   32'(vid_a.pixel_de),   32'h0);
    chk("blank_data_c", 32'(vid_c.pixel_data), 32'h0);

    // Checkerboard, then a mid-frame request for the ramp.
    mode_sel = 3'd1;
    pix(1'b1, 0, 0);
    chk("chk_mode", 32'(cur_mode_a), 32'h1);
    chk("chk_00",   32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 32, 0);
    chk("chk_32_0", 32'(vid_a.pixel_data), 32'h000000);
    pix(1'b1, 32, 32);
    chk("chk_32_32", 32'(vid_a.pixel_data), 32'hFFFFFF);
    mode_sel = 3'd2;
    pix(1'b1, 100, 50);
    chk("midframe_mode", 32'(cur_mode_a), 32'h1);
    chk("midframe_data", 32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 101, 50);
    chk("midframe_mode2", 32'(cur_mode_a), 32'h1);
    pix(1'b0, 102, 50);
    pix(1'b1, 0, 0);
    chk("ramp_mode", 32'(cur_mode_a), 32'h2);
    chk("ramp_x0",   32'(vid_a.pixel_data), 32'h000000);
    for (int i = 1; i <= 4; i++) pix(1'b1, i, 0);
    chk("ramp_x4", 32'(vid_a.pixel_data), 32'h010101);
    pix(1'b1, 799, 0);
    chk("ramp_x799",   32'(vid_a.pixel_data), 32'hC7C7C7);
    chk("ramp_x799_c", 32'(vid_c.pixel_data), 32'h6318);

    // Border.
    mode_sel = 3'd3;
    pix(1'b1, 0, 0);
    chk("border_mode", 32'(cur_mode_a), 32'h3);
    chk("border_00",   32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 5, 5);
    chk("border_in",     32'(vid_a.pixel_data), 32'h000000);
    pix(1'b1, 799, 5);
    chk("border_right",  32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 5, 599);
    chk("border_bottom", 32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 798, 598);
    chk("border_inner",  32'(vid_a.pixel_data), 32'h000000);

    // Reset mid-frame at (300,200) for three cycles.
    pix(1'b1, 299, 200);
    rst = 1'b1;
    for (int i = 300; i < 303; i++) begin
      pix(1'b1, i, 200);
      chk("midrst_data", 32'(vid_a.pixel_data), 32'h0);
      chk("midrst_de",   32'(vid_a.pixel_de),   32'h0);
      chk("midrst_mode", 32'(cur_mode_a),       32'h0);
    end
    rst = 1'b0;
    mode_sel = 3'd4;
    pix(1'b1, 303, 200);
    chk("post_rst_mode", 32'(cur_mode_a), 32'h0);
    chk("post_rst_de",   32'(vid_a.pixel_de), 32'h1);
    chk("post_rst_data", 32'(vid_a.pixel_data), 32'hFFFFFF);
    pix(1'b1, 0, 0);
    chk("post_rst_latch", 32'(cur_mode_a), 32'h4);
    chk("box_origin_out", 32'(vid_a.pixel_data), 32'h0000FF);
    pix(1'b1, 1, 1);
    chk("box_11_in", 32'(vid_a.pixel_data), 32'hFF0000);
    pix(1'b1, 64, 64);
    chk("box_64_in", 32'(vid_a.pixel_data), 32'hFF0000);
    pix(1'b1, 65, 1);
    chk("box_65_out", 32'(vid_a.pixel_data), 32'h0000FF);

    // Bouncing box on a 100x80 screen from a fresh reset.
    rst = 1'b1;
    pix(1'b0, 0, 0);
    h_disp = 11'd100; v_disp = 11'd80;
    pix(1'b0, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      ebx = (k <= 36) ? k : 72 - k;
      if      (k <= 16) eby = k;
      else if (k <= 32) eby = 32 - k;
      else              eby = k - 32;
      pix(1'b1, 0, 0);
      chk("bounce_mode", 32'(cur_mode_a), 32'h4);
      chk("bounce_00",   32'(vid_a.pixel_data), 32'h0000FF);
      pix(1'b1, ebx, eby);
      chk("bounce_tl", 32'(vid_a.pixel_data), 32'hFF0000);
      pix(1'b1, ebx + 63, eby);
      chk("bounce_tr", 32'(vid_a.pixel_data), 32'hFF0000);
      pix(1'b1, ebx + 64, eby);
      chk("bounce_right_out", 32'(vid_a.pixel_data), 32'h0000FF);
      pix(1'b1, ebx, eby + 64);
      chk("bounce_below_out", 32'(vid_a.pixel_data), 32'h0000FF);
      if (ebx > 0) begin
        pix(1'b1, ebx - 1, eby);
        chk("bounce_left_out", 32'(vid_a.pixel_data), 32'h0000FF);
      end
    end
    pix(1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
- Parametrised LCD test-pattern source. It sits between the LCD timing driver (which supplies pixel_xpos, pixel_ypos, de) and the RGB output stage.
- Generalises the fixed 5-bar colour generator in three ways:
  - configurable bar count and colour depth;
  - runtime-selectable pattern modes, switched only at frame boundaries;
  - an animated bouncing box, which needs per-frame state.
- Bar boundaries come from an incremental accumulator, so no dividers are used.

Parameters:
COLOR_W, 8, bits per channel (1..8); pixel_data width is 3*COLOR_W.
NUM_BARS, 5, colour-bar count (2..64; must be less than h_disp).
CELL_LOG2, 5, checkerboard cell size is 2**CELL_LOG2 pixels.
BOX_SIZE, 64, bouncing-box edge in pixels (must be less than h_disp and less than v_disp).
XY_W, 11, coordinate width.

Ports:
lcd_pclk  in  1  pixel clock; the only clock.
rst  in  1  synchronous, active-high reset.
de  in  1  active-video strobe; x advances by 1 per de cycle within a line.
pixel_xpos  in  XY_W  current pixel column.
pixel_ypos  in  XY_W  current pixel row.
h_disp  in  XY_W  horizontal resolution; static while running.
v_disp  in  XY_W  vertical resolution; static while running.
mode_sel  in  3  requested pattern mode.
pixel_data  out  3*COLOR_W  RGB, R in the MSBs.
pixel_de  out  1  de delayed to align with pixel_data.
cur_mode  out  3  mode currently being displayed.

Behaviour:
- Reset (sampled on lcd_pclk):
  - Outputs: pixel_data=0, pixel_de=0, cur_mode=0.
  - Internal state: accumulator=0, bar_idx=0, box_x=box_y=0, dir_x=+1, dir_y=+1.
  - Reset asserted mid-frame takes effect on the next edge. Normal output resumes on the cycle after rst falls, with mode 0 until the first frame_start.
- Latency:
  - Exactly 1 cycle from inputs to pixel_data/pixel_de.
  - When de=0, pixel_data is 0 on the following cycle.
- frame_start is the condition de and pixel_xpos==0 and pixel_ypos==0. On that cycle, simultaneously:
  - cur_mode latches mode_sel, and the new mode applies to this same pixel.
  - The box position updates. The updated position is used from this pixel onward.
  - mode_sel changes at any other time are ignored until the next frame_start.
- Bar index:
  - bar_idx must equal floor(x*NUM_BARS/h_disp) for each de pixel.
  - At x==0: acc=0, idx=0.
  - Each following de pixel: acc += NUM_BARS; if acc >= h_disp then acc -= h_disp and idx++.
  - Accumulator width is XY_W+1.
- Palette (8-bit values, truncated to the top COLOR_W bits), indexed by idx mod 8: WHITE, BLACK, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA.
- Modes:
  - 0: colour bars, palette[bar_idx mod 8].
  - 1: checkerboard, WHITE if x[CELL_LOG2]^y[CELL_LOG2]==0, else BLACK.
  - 2: gray ramp, all channels = x[9:2].
  - 3: border, WHITE if x==0, y==0, x==h_disp-1 or y==v_disp-1; else BLACK.
  - 4: bouncing box, RED inside box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE; BLUE elsewhere.
  - 5-7: BLACK.
- Box update, once per frame_start, each axis independently:
  - Moving +1: if box_x+BOX_SIZE == h_disp then dir_x=-1 and box_x-=1; else box_x+=1.
  - Moving -1: if box_x == 0 then dir_x=+1 and box_x+=1; else box_x-=1.
  - The y axis uses the same rules with v_disp.
  - The box never leaves the screen; an edge hit reverses direction within the same update.
- Box position advances in every frame regardless of mode, so switching to mode 4 shows live state.

Decomposition:
- Shared package lcd_pkg:
  - 24-bit colour constants: WHITE, BLACK, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA.
  - Mode encodings: MODE_BARS=0, MODE_CHECK=1, MODE_RAMP=2, MODE_BORDER=3, MODE_BOX=4.
  - The 8-entry palette function.
- One sub-module, lcd_bar_index: the accumulator/index counter, so the bar-index logic can be tested standalone.
- The box mover stays inline.

Test Plan:
- Bars, h_disp=800, NUM_BARS=5, mode 0, one full line -> x=0..159 gives FFFFFF, x=160 gives 000000, x=320 gives FF0000, x=480 gives 00FF00, x=640..799 gives 0000FF, each 1 cycle after input.
- NUM_BARS=7, h_disp=800, full sweep -> index increments at x=115, 229, 343, 458, 572, 686; compared against a floor(x*7/800) model for every pixel.
- mode_sel changed 1->2 at mid-frame pixel (100,50) -> cur_mode stays 1 until frame_start; at (0,0) of the next frame pixel_data=000000 and cur_mode=2; x=4 gives 010101.
- Mode 4, h_disp=100, v_disp=80, BOX_SIZE=64, 40 frames -> box_x runs 0..36, then 35; box_y runs 0..16, then 15; pixel (box_x, box_y) is RED and (box_x+64, box_y) is BLUE.
- rst asserted at pixel (300,200) for 3 cycles -> pixel_data=0, pixel_de=0, cur_mode=0; box resets to (0,0); next frame latches mode_sel.
- COLOR_W=5, mode 0 -> RED bar outputs 15'h7C00, YELLOW 15'h7FE0; de=0 gives 0 next cycle.
